// File: rtl/ysyx_22051145_wbu_if.sv
// Write-back unit bus: EXU result handshake, LSU result strobe, register-file
// write port, bypass lookup and queue occupancy.
interface ysyx_22051145_wbu_if;
  // EXU: a result transfers on a rising edge where exu_valid && exu_ready are
  // both high; the EXU holds exu_rd/exu_data stable while exu_valid && !exu_ready.
  // LSU: lsu_valid qualifies lsu_rd/lsu_data and is always accepted.
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        en_w;
  logic [4:0]  waddr;
  logic [63:0] w_data;
  logic [4:0]  byp_addr;
  logic        byp_hit;
  logic [63:0] byp_data;
  logic [2:0]  pending;

  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, byp_addr,
    output exu_ready, en_w, waddr, w_data, byp_hit, byp_data, pending
  );

  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, byp_addr,
    input  exu_ready, en_w, waddr, w_data, byp_hit, byp_data, pending
  );
endinterface

// File: rtl/ysyx_22051145_wbu.sv
// Write-back unit: queues EXU results in a small FIFO, gives LSU results
// priority into a registered register-file write stage, and offers a bypass.
module ysyx_22051145_wbu #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22051145_wbu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]  r_mem_rd   [DEPTH];
  logic [63:0] r_mem_data [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic        r_en;
  logic [4:0]  r_waddr;
  logic [63:0] r_wdata;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_rd;
  logic [63:0]   w_head_data;
  logic [AW-1:0] w_idx;
  logic          w_byp_hit;
  logic [63:0]   w_byp_data;

  assign w_full      = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_push      = bus.exu_valid && bus.exu_ready;
  // Pop decision uses the registered count, so a same-cycle push never falls through.
  assign w_pop       = !rst && !bus.lsu_valid && !w_empty;
  assign w_head_rd   = r_mem_rd[r_rp];
  assign w_head_data = r_mem_data[r_rp];

  assign bus.exu_ready = !w_full && !rst;
  assign bus.en_w      = r_en;
  assign bus.waddr     = r_waddr;
  assign bus.w_data    = r_wdata;
  assign bus.pending   = 3'(r_cnt);
  assign bus.byp_hit   = w_byp_hit;
  assign bus.byp_data  = w_byp_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wp]   <= bus.exu_rd;
      r_mem_data[r_wp] <= bus.exu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // rd == 0 results are consumed but write zeros with the enable low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (bus.lsu_valid) begin
      r_en    <= (bus.lsu_rd != 5'd0);
      r_waddr <= (bus.lsu_rd != 5'd0) ? bus.lsu_rd : 5'd0;
      r_wdata <= (bus.lsu_rd != 5'd0) ? bus.lsu_data : 64'd0;
    end else if (w_pop) begin
      r_en    <= (w_head_rd != 5'd0);
      r_waddr <= (w_head_rd != 5'd0) ? w_head_rd : 5'd0;
      r_wdata <= (w_head_rd != 5'd0) ? w_head_data : 64'd0;
    end else begin
      r_en    <= 1'b0;
    end
  end

  // Scan oldest to youngest so the newest match overrides older ones.
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = '0;
    w_idx      = '0;
    if (bus.byp_addr != 5'd0) begin
      if (r_en && (r_waddr == bus.byp_addr)) begin
        w_byp_hit  = 1'b1;
        w_byp_data = r_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = r_rp + AW'(k);
        if (((AW+1)'(k) < r_cnt) && (r_mem_rd[w_idx] == bus.byp_addr)) begin
          w_byp_hit  = 1'b1;
          w_byp_data = r_mem_data[w_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22051145_wbu.sv
// Self-checking bench for the write-back unit: vector table, directed
// corner sequences and a random stream against an in-order EXU scoreboard.
module tb_ysyx_22051145_wbu;
  logic clk;
  logic rst;
  ysyx_22051145_wbu_if bus();

  ysyx_22051145_wbu #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // EXU writes expected in order, entry = {rd, data}.
  logic [68:0] exp_q[$];
  logic        rst_prev   = 1'b1;
  logic        lsu_prev_v = 1'b0;
  logic [4:0]  lsu_prev_rd;
  logic [63:0] lsu_prev_data;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: compares the write port against what the inputs sampled
  // in the previous cycle require, then captures this cycle's inputs.
  always @(negedge clk) begin
    logic [68:0] e;
    if (rst_prev) begin
      chk("mon_rst_out", {bus.en_w, bus.waddr, bus.w_data}, 70'd0);
    end else if (lsu_prev_v) begin
      if (lsu_prev_rd != 5'd0) chk("mon_lsu_wr", {bus.en_w, bus.waddr, bus.w_data}, {1'b1, lsu_prev_rd, lsu_prev_data});
      else                     chk("mon_lsu_rd0", {bus.en_w, bus.waddr, bus.w_data}, 70'd0);
    end else if (bus.en_w) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_wr", {bus.waddr, bus.w_data}, 69'h1f_ffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("mon_exu_wr", {bus.waddr, bus.w_data}, e);
      end
    end
    rst_prev      = rst;
    lsu_prev_v    = bus.lsu_valid && !rst;
    lsu_prev_rd   = bus.lsu_rd;
    lsu_prev_data = bus.lsu_data;
    if (rst) exp_q.delete();
    else if (bus.exu_valid && bus.exu_ready && bus.exu_rd != 5'd0)
      exp_q.push_back({bus.exu_rd, bus.exu_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.exu_valid = 1'b0;
    bus.exu_rd    = '0;
    bus.exu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
  endtask

  task automatic drive_exu(input logic [4:0] rd, input logic [63:0] d);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = rd;
    bus.exu_data  = d;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [63:0] d);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  task automatic chk_wr(input string name, input logic en, input logic [4:0] a, input logic [63:0] d);
    chk(name, {bus.en_w, bus.waddr, bus.w_data}, {en, a, d});
  endtask

  typedef struct {
    logic        is_lsu;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exp_en;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  logic stall;

  initial begin
    vecs[0] = '{1'b1, 5'd1,  64'h0000_0000_0000_00a1, 1'b1, 5'd1,  64'h0000_0000_0000_00a1};
    vecs[1] = '{1'b0, 5'd2,  64'hdead_beef_0000_0002, 1'b1, 5'd2,  64'hdead_beef_0000_0002};
    vecs[2] = '{1'b1, 5'd0,  64'h1111_2222_3333_4444, 1'b0, 5'd0,  64'd0};
    vecs[3] = '{1'b0, 5'd31, 64'hffff_ffff_ffff_ffff, 1'b1, 5'd31, 64'hffff_ffff_ffff_ffff};
    vecs[4] = '{1'b0, 5'd0,  64'h0000_0000_0000_00ff, 1'b0, 5'd0,  64'd0};
    vecs[5] = '{1'b1, 5'd17, 64'h8000_0000_0000_0001, 1'b1, 5'd17, 64'h8000_0000_0000_0001};

    idle();
    bus.byp_addr = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", bus.exu_ready, 0);
    chk("rst_pending", bus.pending, 0);
    chk_wr("rst_out", 1'b0, 5'd0, 64'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_ready", bus.exu_ready, 1);

    // Table: isolated writes, then one idle cycle must hold waddr/w_data.
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vecs[i].is_lsu) drive_lsu(vecs[i].rd, vecs[i].data);
      else                drive_exu(vecs[i].rd, vecs[i].data);
      tick();
      idle();
      if (!vecs[i].is_lsu) begin
        settle();
        chk($sformatf("vec%0d_pending", i), bus.pending, 1);
        tick();
      end
      settle();
      chk_wr($sformatf("vec%0d_wr", i), vecs[i].exp_en, vecs[i].exp_waddr, vecs[i].exp_data);
      chk($sformatf("vec%0d_pend0", i), bus.pending, 0);
      tick();
      settle();
      chk_wr($sformatf("vec%0d_hold", i), 1'b0, vecs[i].exp_waddr, vecs[i].exp_data);
    end

    // EXU rd=5 latency and pending 1 then 0.
    tick();
    drive_exu(5'd5, 64'h1234);
    settle();
    chk("lat_pend_before", bus.pending, 0);
    tick();
    idle();
    settle();
    chk("lat_pend_1", bus.pending, 1);
    chk("lat_en_early", bus.en_w, 0);
    tick();
    settle();
    chk_wr("lat_wr", 1'b1, 5'd5, 64'h1234);
    chk("lat_pend_0", bus.pending, 0);

    // LSU and EXU in the same cycle: LSU writes first.
    tick();
    drive_lsu(5'd7, 64'haa);
    drive_exu(5'd3, 64'hbb);
    tick();
    idle();
    settle();
    chk_wr("prio_lsu_first", 1'b1, 5'd7, 64'haa);
    tick();
    settle();
    chk_wr("prio_exu_second", 1'b1, 5'd3, 64'hbb);

    // LSU held 4 cycles while EXU pushes: queue fills and EXU stalls.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_lsu(5'(10 + i), {$urandom, $urandom});
      drive_exu(5'(20 + ((i < 2) ? i : 2)), 64'(64'h500 + ((i < 2) ? i : 2)));
      settle();
      chk($sformatf("stall_ready%0d", i), bus.exu_ready, (i < 2) ? 1 : 0);
      chk($sformatf("stall_pend%0d", i), bus.pending, (i < 2) ? i : 2);
    end
    tick();
    idle();
    settle();
    chk("stall_pend_hold", bus.pending, 2);
    chk_wr("stall_last_lsu", 1'b1, 5'd13, bus.lsu_data === 64'bx ? 64'd0 : lsu_prev_data);
    tick();
    settle();
    chk_wr("stall_drain0", 1'b1, 5'd20, 64'h500);
    chk("stall_drain0_pend", bus.pending, 1);
    tick();
    settle();
    chk_wr("stall_drain1", 1'b1, 5'd21, 64'h501);
    chk("stall_drain1_pend", bus.pending, 0);

    // rd=0 EXU result is popped without a write.
    tick();
    drive_exu(5'd0, 64'hff);
    tick();
    idle();
    settle();
    chk("rd0_pend1", bus.pending, 1);
    tick();
    settle();
    chk_wr("rd0_no_wr", 1'b0, 5'd0, 64'd0);
    chk("rd0_pend0", bus.pending, 0);

    // Bypass: youngest FIFO entry wins, then output stage.
    tick();
    drive_lsu(5'd0, 64'd0);
    drive_exu(5'd9, 64'h11);
    tick();
    drive_exu(5'd9, 64'h22);
    tick();
    bus.exu_valid = 1'b0;
    bus.byp_addr  = 5'd9;
    settle();
    chk("byp_pend2", bus.pending, 2);
    chk("byp_young", {bus.byp_hit, bus.byp_data}, {1'b1, 64'h22});
    bus.byp_addr = 5'd0;
    settle();
    chk("byp_zero", {bus.byp_hit, bus.byp_data}, 65'd0);
    bus.byp_addr = 5'd5;
    settle();
    chk("byp_miss", {bus.byp_hit, bus.byp_data}, 65'd0);
    bus.byp_addr = 5'd9;
    bus.lsu_valid = 1'b0;
    tick();
    settle();
    chk("byp_fifo_over_out", {bus.byp_hit, bus.byp_data}, {1'b1, 64'h22});
    tick();
    settle();
    chk("byp_out_stage", {bus.byp_hit, bus.byp_data}, {1'b1, 64'h22});
    tick();
    settle();
    chk("byp_gone", {bus.byp_hit, bus.byp_data}, 65'd0);

    // Reset with two queued entries and a write in the output stage.
    tick();
    drive_lsu(5'd4, 64'h44);
    drive_exu(5'd12, 64'hc0);
    tick();
    drive_lsu(5'd6, 64'h66);
    drive_exu(5'd13, 64'hc1);
    tick();
    idle();
    rst = 1'b1;
    settle();
    chk("mid_pre_pend", bus.pending, 2);
    chk("mid_pre_en", bus.en_w, 1);
    chk("mid_ready_low", bus.exu_ready, 0);
    tick();
    rst = 1'b0;
    settle();
    chk_wr("mid_rst_out", 1'b0, 5'd0, 64'd0);
    chk("mid_rst_pend", bus.pending, 0);
    chk("mid_rst_ready", bus.exu_ready, 1);
    for (int a = 0; a < 32; a++) begin
      bus.byp_addr = 5'(a);
      #1;
      chk($sformatf("mid_byp%0d", a), bus.byp_hit, 0);
    end
    tick();
    settle();
    chk("mid_no_late_wr", bus.en_w, 0);

    // Random traffic, in-order EXU results checked by the monitor.
    stall = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      bus.lsu_valid = ($urandom_range(0, 9) < 3);
      bus.lsu_rd    = 5'($urandom_range(0, 31));
      bus.lsu_data  = {$urandom, $urandom};
      bus.byp_addr  = 5'($urandom_range(0, 31));
      if (!stall) begin
        bus.exu_valid = ($urandom_range(0, 9) < 6);
        bus.exu_rd    = 5'($urandom_range(0, 31));
        bus.exu_data  = {$urandom, $urandom};
      end
      settle();
      chk("rnd_pend_bound", 32'(bus.pending <= 3'd2), 1);
      stall = bus.exu_valid && !bus.exu_ready;
    end
    tick();
    idle();
    repeat (6) tick();
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_pend", bus.pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
